// File: rtl/ecc_dec_pipe.sv
// rtl/ecc_dec_pipe.sv - two-stage SECDED (extended Hamming) decoder with valid/ready flow control
// and saturating single/double error event counters.
module ecc_dec_pipe #(
  parameter int K      = 8,
  parameter int P0_LSB = 1,
  parameter int CNT_W  = 16,
  // Fixed-point iteration of m = clog2(m+K+1); it settles well within three steps.
  localparam int M0    = $clog2(K + 1),
  localparam int M1    = $clog2(M0 + K + 1),
  localparam int M2    = $clog2(M1 + K + 1),
  localparam int m     = $clog2(M2 + K + 1),
  localparam int n     = m + K
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [n:0]       cw_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [K-1:0]     d_o,
  output logic [m:1]       syndrome_o,
  output logic             sb_err_o,
  output logic             db_err_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o
);

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [n:0]       cw1_q, cw1_d;
  logic [K-1:0]     d2_q, d2_d;
  logic [m:1]       syn2_q, syn2_d;
  logic             sb2_q, sb2_d;
  logic             db2_q, db2_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  logic             en1, en2, xfer_out;
  logic [n:1]       pos, pos_fix;
  logic [m:1]       syn;
  logic             pe, sb_c, db_c;
  logic [K-1:0]     data_c;

  always_comb begin
    en2      = ~v2_q | ready_i;
    en1      = ~v1_q | en2;
    xfer_out = v2_q & ready_i;
  end

  assign ready_o = en1;

  always_comb begin : decode_c
    int k;
    k       = 0;
    pos     = (P0_LSB != 0) ? cw1_q[n:1] : cw1_q[n-1:0];
    pe      = ^cw1_q;
    syn     = '0;
    for (int i = 1; i <= m; i++) begin
      for (int j = 1; j <= n; j++) begin
        if (((j >> (i - 1)) & 1) != 0) syn[i] = syn[i] ^ pos[j];
      end
    end
    sb_c    = 1'b0;
    db_c    = 1'b0;
    pos_fix = pos;
    if (syn == '0) begin
      sb_c = pe;
    end else if (pe && (int'(syn) <= n)) begin
      sb_c = 1'b1;
      for (int j = 1; j <= n; j++) begin
        if (j == int'(syn)) pos_fix[j] = ~pos[j];
      end
    end else begin
      db_c = 1'b1;
    end
    // Data bits occupy every non-power-of-two position, lowest position first.
    data_c = '0;
    for (int j = 1; j <= n; j++) begin
      if ((j & (j - 1)) != 0) begin
        data_c[k] = pos_fix[j];
        k = k + 1;
      end
    end
  end

  always_comb begin
    v1_d     = v1_q;
    cw1_d    = cw1_q;
    v2_d     = v2_q;
    d2_d     = d2_q;
    syn2_d   = syn2_q;
    sb2_d    = sb2_q;
    db2_d    = db2_q;
    sb_cnt_d = sb_cnt_q;
    db_cnt_d = db_cnt_q;
    if (en1) begin
      v1_d = valid_i;
      if (valid_i) cw1_d = cw_i;
    end
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        d2_d   = data_c;
        syn2_d = syn;
        sb2_d  = sb_c;
        db2_d  = db_c;
      end
    end
    if (xfer_out && sb2_q && (sb_cnt_q != {CNT_W{1'b1}})) sb_cnt_d = sb_cnt_q + CNT_W'(1);
    if (xfer_out && db2_q && (db_cnt_q != {CNT_W{1'b1}})) db_cnt_d = db_cnt_q + CNT_W'(1);
    if (clr_cnt_i) begin
      sb_cnt_d = '0;
      db_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      cw1_q    <= '0;
      v2_q     <= 1'b0;
      d2_q     <= '0;
      syn2_q   <= '0;
      sb2_q    <= 1'b0;
      db2_q    <= 1'b0;
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
    end else begin
      v1_q     <= v1_d;
      cw1_q    <= cw1_d;
      v2_q     <= v2_d;
      d2_q     <= d2_d;
      syn2_q   <= syn2_d;
      sb2_q    <= sb2_d;
      db2_q    <= db2_d;
      sb_cnt_q <= sb_cnt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign valid_o    = v2_q;
  assign d_o        = d2_q;
  assign syndrome_o = syn2_q;
  assign sb_err_o   = sb2_q;
  assign db_err_o   = db2_q;
  assign sb_cnt_o   = sb_cnt_q;
  assign db_cnt_o   = db_cnt_q;

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// tb/tb_ecc_dec_pipe.sv - directed and randomized bench for ecc_dec_pipe (K=8, p0 at bit 0, 2-bit counters)
module tb_ecc_dec_pipe;

  localparam int NP = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] cw_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  d_o;
  logic [4:1]  syndrome_o;
  logic        sb_err_o, db_err_o, valid_o;
  logic        ready_i = 1'b0;
  logic        clr_cnt_i = 1'b0;
  logic [1:0]  sb_cnt_o, db_cnt_o;

  ecc_dec_pipe #(.K(8), .P0_LSB(1), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cw_i(cw_i), .valid_i(valid_i), .ready_o(ready_o),
    .d_o(d_o), .syndrome_o(syndrome_o), .sb_err_o(sb_err_o), .db_err_o(db_err_o),
    .valid_o(valid_o), .ready_i(ready_i), .clr_cnt_i(clr_cnt_i),
    .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         s;
    logic       sb;
    logic       db;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   msb = 0;
  int   mdb = 0;

  // Syndrome is the XOR of the indices of all set positions.
  function automatic exp_t ref_dec(input logic [12:0] cw);
    exp_t        r;
    logic [12:0] c;
    logic        pe;
    int          k;
    c = cw; pe = ^cw; k = 0; r.s = 0; r.sb = 1'b0; r.db = 1'b0; r.d = '0;
    for (int j = 1; j <= NP; j++) if (cw[j]) r.s = r.s ^ j;
    if (r.s == 0) r.sb = pe;
    else if (pe && r.s <= NP) begin c[r.s] = ~c[r.s]; r.sb = 1'b1; end
    else r.db = 1'b1;
    for (int j = 1; j <= NP; j++) if ((j & (j - 1)) != 0) begin r.d[k] = c[j]; k++; end
    return r;
  endfunction

  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] c;
    int          k, s;
    c = '0; k = 0; s = 0;
    for (int j = 1; j <= NP; j++) if ((j & (j - 1)) != 0) begin c[j] = d[k]; k++; end
    for (int j = 1; j <= NP; j++) if (c[j]) s = s ^ j;
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
    c[0] = ^c[12:1];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input logic v, input logic [12:0] cw, input logic rdy, input logic clr,
                     output logic acc);
    exp_t e;
    valid_i = v; cw_i = cw; ready_i = rdy; clr_cnt_i = clr;
    #1;
    chk("ready_o", ready_o, (q.size() < 2) || rdy);
    if (q.size() == 0) chk("valid_idle", valid_o, 1'b0);
    if (q.size() == 2) chk("valid_full", valid_o, 1'b1);
    acc = v && ready_o;
    if (valid_o && rdy && q.size() > 0) begin
      e = q.pop_front();
      chk("d_o", d_o, e.d);
      chk("syndrome", syndrome_o, e.s);
      chk("sb_err", sb_err_o, e.sb);
      chk("db_err", db_err_o, e.db);
      if (e.sb && msb < 3) msb++;
      if (e.db && mdb < 3) mdb++;
    end
    if (clr) begin msb = 0; mdb = 0; end
    if (acc) q.push_back(ref_dec(cw));
    @(posedge clk);
    @(negedge clk);
    chk("sb_cnt", sb_cnt_o, msb);
    chk("db_cnt", db_cnt_o, mdb);
  endtask

  // Single beat into an empty pipe, checked for 2-cycle latency and literal values.
  task automatic beat_lit(input logic [12:0] cw, input logic [7:0] d, input int s,
                          input logic sb, input logic db);
    logic a;
    cyc(1'b1, cw, 1'b1, 1'b0, a);
    chk("lat_accept", a, 1'b1);
    chk("lat_s1", valid_o, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("lat_s2", valid_o, 1'b1);
    chk("lit_d", d_o, d);
    chk("lit_syn", syndrome_o, s);
    chk("lit_sb", sb_err_o, sb);
    chk("lit_db", db_err_o, db);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    logic [12:0] tv[5];
    logic [7:0]  td[5];
    int          ts[5];
    logic        tsb[5], tdb[5];
    logic [12:0] bp[4];
    logic [12:0] c;
    logic [7:0]  hold_d;
    logic [4:1]  hold_s;
    int          idx, r, b1, b2;

    tv  = '{13'h1EEE, 13'h1EEE ^ 13'h0020, 13'h1EEE ^ 13'h0001, 13'h1EEE ^ 13'h0028, 13'h1EEE ^ 13'h0112};
    td  = '{8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hFF};
    ts  = '{0, 5, 0, 6, 13};
    tsb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tdb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_d", d_o, 8'h00);
    chk("rst_syn", syndrome_o, 4'h0);
    chk("rst_flags", {sb_err_o, db_err_o}, 2'b00);
    chk("rst_cnt", {sb_cnt_o, db_cnt_o}, 4'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", ready_o, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) beat_lit(tv[i], td[i], ts[i], tsb[i], tdb[i]);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, a);

    for (int i = 0; i < 300; i++) begin
      c = enc(8'($urandom));
      r = $urandom_range(0, 9);
      b1 = $urandom_range(0, 12);
      b2 = (b1 + $urandom_range(1, 12)) % 13;
      if (r >= 4 && r <= 6) c[b1] = ~c[b1];
      else if (r >= 7 && r <= 8) begin c[b1] = ~c[b1]; c[b2] = ~c[b2]; end
      else if (r == 9) c = 13'($urandom);
      cyc($urandom_range(0, 3) != 0, c, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, a);
    end
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, a);

    for (int i = 0; i < 4; i++) begin
      bp[i] = enc(8'($urandom));
      if (i[0]) bp[i][$urandom_range(0, 12)] ^= 1'b1;
    end
    idx = 0;
    hold_d = '0;
    hold_s = '0;
    for (int t = 0; t < 12; t++) begin
      cyc(idx < 4, bp[idx < 4 ? idx : 0], t >= 3, 1'b0, a);
      if (a) idx++;
      if (t == 1) begin
        hold_d = d_o;
        hold_s = syndrome_o;
        chk("bp_valid", valid_o, 1'b1);
      end
      if (t == 2) begin
        chk("bp_accepted", idx, 2);
        chk("bp_hold_d", d_o, hold_d);
        chk("bp_hold_syn", syndrome_o, hold_s);
      end
    end
    chk("bp_all_in", idx, 4);
    chk("bp_all_out", q.size(), 0);

    cyc(1'b0, '0, 1'b1, 1'b1, a);
    for (int i = 0; i < 5; i++) begin
      c = enc(8'($urandom));
      b1 = $urandom_range(1, 12);
      c[b1] = ~c[b1];
      cyc(1'b1, c, 1'b1, 1'b0, a);
    end
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("sb_saturate", sb_cnt_o, 2'd3);
    cyc(1'b1, 13'h1EEE ^ 13'h0028, 1'b1, 1'b0, a);
    cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("clr_db_pending", db_err_o, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, a);
    chk("clr_sb", sb_cnt_o, 2'd0);
    chk("clr_db", db_cnt_o, 2'd0);

    cyc(1'b1, enc(8'h5A), 1'b0, 1'b0, a);
    cyc(1'b1, enc(8'hA5) ^ 13'h0004, 1'b0, 1'b0, a);
    chk("inflight", q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_d", d_o, 8'h00);
    chk("arst_syn", syndrome_o, 4'h0);
    chk("arst_flags", {sb_err_o, db_err_o}, 2'b00);
    chk("arst_cnt", {sb_cnt_o, db_cnt_o}, 4'h0);
    q.delete();
    msb = 0;
    mdb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, a);
    beat_lit(13'h1EEE, 8'hFF, 0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, a);
    chk("final_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
